// File: rtl/toggle_cov_accum.sv
`default_nettype none
// ============================================================================
// toggle_cov_accum: sticky toggle-coverage bitmap, running totals, and a
// chunked valid/ready dump of the bitmap. Optional macro COV_PLATEAU_EN.
// Rev 1.0
// ============================================================================
module toggle_cov_accum #(
    parameter int WIDTH          = 64,
    parameter int CHUNK          = 32,
    parameter int CNT_W          = 32,
    parameter int PLATEAU_CYCLES = 1024,
    localparam int NCHUNK        = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int PC_W          = $clog2(WIDTH + 1),
    localparam int IDX_W         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               toggle_valid,
    input  logic [WIDTH-1:0]   toggle,
    input  logic               clear,
    input  logic               finish,
    output logic [PC_W-1:0]    cov_count,
    output logic [PC_W-1:0]    new_hits,
    output logic [CNT_W-1:0]   cycles,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [CHUNK-1:0]   dump_data,
    output logic [IDX_W-1:0]   dump_index,
    output logic               dump_last,
    output logic               done
`ifdef COV_PLATEAU_EN
    ,
    output logic               plateau
`endif
);

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_DUMP  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bitmap_q, bitmap_d;
    logic [PC_W-1:0]     cov_count_q, cov_count_d;
    logic [PC_W-1:0]     new_hits_q, new_hits_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic                dump_valid_q, dump_valid_d;
    logic [IDX_W-1:0]    dump_index_q, dump_index_d;
    logic                done_q, done_d;

    logic [PC_W-1:0]     w_fresh_cnt;
    logic                w_accept;
    logic                w_at_last;
    logic [NCHUNK*CHUNK-1:0] w_padded;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s = s + PC_W'(v[i]);
        end
        return s;
    endfunction

    assign w_fresh_cnt = popcount(toggle & ~bitmap_q);
    assign w_accept    = !clear && (state_q == S_ACCUM) && toggle_valid;
    assign w_at_last   = (dump_index_q == IDX_W'(NCHUNK - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_ACCUM;
            bitmap_q     <= '0;
            cov_count_q  <= '0;
            new_hits_q   <= '0;
            cycles_q     <= '0;
            dump_valid_q <= 1'b0;
            dump_index_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitmap_q     <= bitmap_d;
            cov_count_q  <= cov_count_d;
            new_hits_q   <= new_hits_d;
            cycles_q     <= cycles_d;
            dump_valid_q <= dump_valid_d;
            dump_index_q <= dump_index_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bitmap_d     = bitmap_q;
        cov_count_d  = cov_count_q;
        new_hits_d   = '0;
        cycles_d     = cycles_q;
        dump_valid_d = dump_valid_q;
        dump_index_d = dump_index_q;
        done_d       = done_q;

        if (clear) begin
            state_d      = S_ACCUM;
            bitmap_d     = '0;
            cov_count_d  = '0;
            cycles_d     = '0;
            dump_valid_d = 1'b0;
            dump_index_d = '0;
            done_d       = 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    // A sample arriving with finish is still folded in.
                    if (toggle_valid) begin
                        bitmap_d    = bitmap_q | toggle;
                        new_hits_d  = w_fresh_cnt;
                        cov_count_d = cov_count_q + w_fresh_cnt;
                        if (cycles_q != {CNT_W{1'b1}}) begin
                            cycles_d = cycles_q + CNT_W'(1);
                        end
                    end
                    if (finish) begin
                        state_d      = S_DUMP;
                        dump_valid_d = 1'b1;
                        dump_index_d = '0;
                    end
                end
                S_DUMP: begin
                    if (dump_valid_q && dump_ready) begin
                        if (w_at_last) begin
                            dump_valid_d = 1'b0;
                            done_d       = 1'b1;
                            state_d      = S_DONE;
                        end else begin
                            dump_index_d = dump_index_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_ACCUM;
                end
            endcase
        end
    end

    // Zero-pad the bitmap to a whole number of chunks before selecting.
    always_comb begin
        w_padded              = '0;
        w_padded[WIDTH-1:0]   = bitmap_q;
        dump_data             = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (dump_index_q == IDX_W'(i)) begin
                dump_data = w_padded[i*CHUNK +: CHUNK];
            end
        end
    end

    assign cov_count  = cov_count_q;
    assign new_hits   = new_hits_q;
    assign cycles     = cycles_q;
    assign dump_valid = dump_valid_q;
    assign dump_index = dump_index_q;
    assign dump_last  = dump_valid_q && w_at_last;
    assign done       = done_q;

`ifdef COV_PLATEAU_EN
    localparam int RUN_W = $clog2(PLATEAU_CYCLES + 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             plateau_q, plateau_d;

    always_comb begin
        run_d     = run_q;
        plateau_d = plateau_q;
        if (clear) begin
            run_d     = '0;
            plateau_d = 1'b0;
        end else if (w_accept) begin
            if (w_fresh_cnt != '0) begin
                run_d = '0;
            end else if (run_q != RUN_W'(PLATEAU_CYCLES)) begin
                run_d = run_q + RUN_W'(1);
            end
            if (run_d == RUN_W'(PLATEAU_CYCLES)) begin
                plateau_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q     <= '0;
            plateau_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            plateau_q <= plateau_d;
        end
    end

    assign plateau = plateau_q;
`endif

endmodule
`default_nettype wire
